// File: rtl/seg_write_back_reg.sv
// MIPS write-back stage: MEM/WB pipeline latch, load-data extraction, link writeback,
// stall/flush control and a retired-writeback counter.
module seg_write_back_reg #(
    parameter int unsigned LEN        = 32,
    parameter int unsigned NB_ADDR    = 5,
    parameter int unsigned NB_CTRL_WB = 6,
    parameter int unsigned NB_CNT     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [LEN-1:0]        i_read_data,
    input  logic [LEN-1:0]        i_ALU_result,
    input  logic [LEN-1:0]        i_pc_plus_8,
    input  logic [NB_ADDR-1:0]    i_write_register,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    output logic                  o_valid,
    output logic                  o_RegWrite,
    output logic [LEN-1:0]        o_write_data,
    output logic [NB_ADDR-1:0]    o_write_register,
    output logic                  o_misaligned,
    output logic [NB_CNT-1:0]     o_retired_count
);

    logic                  valid_q;
    logic [NB_CTRL_WB-1:0] ctrl_q;
    logic [LEN-1:0]        read_data_q;
    logic [LEN-1:0]        alu_q;
    logic [LEN-1:0]        pc8_q;
    logic [NB_ADDR-1:0]    wreg_q;
    logic [NB_CNT-1:0]     cnt_q;
    logic [NB_CNT-1:0]     cnt_d;

    logic                  reg_write_en;
    logic [1:0]            wb_sel;
    logic [1:0]            ld_size;
    logic                  ld_unsigned;
    logic [1:0]            off;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [LEN-1:0]        load_data;
    logic                  mis_cond;

    assign reg_write_en = ctrl_q[5];
    assign wb_sel       = ctrl_q[4:3];
    assign ld_size      = ctrl_q[2:1];
    assign ld_unsigned  = ctrl_q[0];
    assign off          = alu_q[1:0];

    // Flush clears only valid/ctrl; data fields are don't-care in a bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            read_data_q <= '0;
            alu_q       <= '0;
            pc8_q       <= '0;
            wreg_q      <= '0;
            cnt_q       <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (i_flush) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end else if (!i_stall) begin
                valid_q     <= i_valid;
                ctrl_q      <= i_ctrl_wb_bus;
                read_data_q <= i_read_data;
                alu_q       <= i_ALU_result;
                pc8_q       <= i_pc_plus_8;
                wreg_q      <= i_write_register;
            end
        end
    end

    // A write held by stall is counted once, on the edge where it finally leaves.
    always_comb begin
        cnt_d = cnt_q;
        if (o_RegWrite && !i_stall) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        lane_byte = read_data_q[7:0];
        unique case (off)
            2'd0: lane_byte = read_data_q[7:0];
            2'd1: lane_byte = read_data_q[15:8];
            2'd2: lane_byte = read_data_q[23:16];
            2'd3: lane_byte = read_data_q[31:24];
            default: lane_byte = read_data_q[7:0];
        endcase
        lane_half = off[1] ? read_data_q[31:16] : read_data_q[15:0];
    end

    always_comb begin
        load_data = read_data_q;
        mis_cond  = 1'b0;
        case (ld_size)
            2'b00: begin
                load_data = {{(LEN-8){~ld_unsigned & lane_byte[7]}}, lane_byte};
            end
            2'b01: begin
                load_data = {{(LEN-16){~ld_unsigned & lane_half[15]}}, lane_half};
                mis_cond  = off[0];
            end
            default: begin
                load_data = read_data_q;
                mis_cond  = |off;
            end
        endcase
    end

    always_comb begin
        o_write_data = alu_q;
        case (wb_sel)
            2'b01:   o_write_data = load_data;
            2'b10:   o_write_data = pc8_q;
            default: o_write_data = alu_q;
        endcase
    end

    assign o_valid          = valid_q;
    assign o_write_register = wreg_q;
    assign o_misaligned     = valid_q & (wb_sel == 2'b01) & mis_cond;
    assign o_RegWrite       = valid_q & reg_write_en & (|wreg_q) & ~o_misaligned;
    assign o_retired_count  = cnt_q;

endmodule

// File: tb/tb_seg_write_back_reg.sv
// Scoreboard bench for seg_write_back_reg: stimulus queues expected outputs, a negedge
// monitor pops and compares them; a second instance with NB_CNT=4 checks counter wrap.
module tb_seg_write_back_reg;

    logic        clk;
    logic        rst_n;
    logic        valid, stall, flush;
    logic [31:0] rdat, alu, pc8;
    logic [4:0]  rd;
    logic [5:0]  ctrl;

    logic        o_valid, o_rw, o_mis;
    logic [31:0] o_data, o_cnt;
    logic [4:0]  o_reg;
    logic        o4_valid, o4_rw, o4_mis;
    logic [31:0] o4_data;
    logic [4:0]  o4_reg;
    logic [3:0]  o4_cnt;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned due;
        string       name;
        logic        v, rw, mis, chk_data;
        logic [31:0] data;
        logic [4:0]  rg;
        logic [31:0] cnt;
    } exp_t;
    exp_t q[$];

    seg_write_back_reg dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_read_data(rdat), .i_ALU_result(alu), .i_pc_plus_8(pc8),
        .i_write_register(rd), .i_ctrl_wb_bus(ctrl),
        .o_valid(o_valid), .o_RegWrite(o_rw), .o_write_data(o_data),
        .o_write_register(o_reg), .o_misaligned(o_mis), .o_retired_count(o_cnt)
    );

    seg_write_back_reg #(.NB_CNT(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_read_data(rdat), .i_ALU_result(alu), .i_pc_plus_8(pc8),
        .i_write_register(rd), .i_ctrl_wb_bus(ctrl),
        .o_valid(o4_valid), .o_RegWrite(o4_rw), .o_write_data(o4_data),
        .o_write_register(o4_reg), .o_misaligned(o4_mis), .o_retired_count(o4_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the entry due this cycle.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".valid"}, 32'(o_valid), 32'(e.v));
            chk({e.name, ".RegWrite"}, 32'(o_rw), 32'(e.rw));
            chk({e.name, ".misaligned"}, 32'(o_mis), 32'(e.mis));
            chk({e.name, ".count"}, o_cnt, e.cnt);
            chk({e.name, ".count4"}, 32'(o4_cnt), 32'(e.cnt[3:0]));
            if (e.chk_data) begin
                chk({e.name, ".data"}, o_data, e.data);
                chk({e.name, ".reg"}, 32'(o_reg), 32'(e.rg));
            end
        end
    end

    task automatic step(input string nm, input logic v, input logic st, input logic fl,
                        input logic [5:0] c, input logic [31:0] a, input logic [31:0] r,
                        input logic [31:0] p, input logic [4:0] d,
                        input logic ev, input logic erw, input logic emis, input logic echk,
                        input logic [31:0] edata, input logic [4:0] erg,
                        input logic [31:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        valid = v; stall = st; flush = fl; ctrl = c; alu = a; rdat = r; pc8 = p; rd = d;
        e.due = cyc + 1; e.name = nm; e.v = ev; e.rw = erw; e.mis = emis;
        e.chk_data = echk; e.data = edata; e.rg = erg; e.cnt = ecnt;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (q.size() > 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".valid"}, 32'(o_valid), 32'd0);
        chk({nm, ".RegWrite"}, 32'(o_rw), 32'd0);
        chk({nm, ".data"}, o_data, 32'd0);
        chk({nm, ".reg"}, 32'(o_reg), 32'd0);
        chk({nm, ".misaligned"}, 32'(o_mis), 32'd0);
        chk({nm, ".count"}, o_cnt, 32'd0);
        chk({nm, ".count4"}, 32'(o4_cnt), 32'd0);
    endtask

    localparam logic [5:0] LW  = 6'b1_01_10_0;
    localparam logic [5:0] LB  = 6'b1_01_00_0;
    localparam logic [5:0] LBU = 6'b1_01_00_1;
    localparam logic [5:0] LH  = 6'b1_01_01_0;
    localparam logic [5:0] LHU = 6'b1_01_01_1;
    localparam logic [5:0] JAL = 6'b1_10_00_0;
    localparam logic [5:0] ALU = 6'b1_00_00_0;
    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        rst_n = 1'b0; valid = 0; stall = 0; flush = 0;
        ctrl = '0; alu = '0; rdat = '0; pc8 = '0; rd = '0;
        #3;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        //   name     v st fl ctrl alu          rdat          pc8           rd
        //            ev rw mis chk data        reg cnt
        step("lw",    1, 0, 0, LW,  32'h100,     32'hDEADBEEF, 32'h0,        5'd8,
                      1, 1, 0, 1, 32'hDEADBEEF, 5'd8, 32'd0);
        step("lb",    1, 0, 0, LB,  32'h103,     RD,           32'h0,        5'd9,
                      1, 1, 0, 1, 32'hFFFFFF80, 5'd9, 32'd1);
        step("lbu",   1, 0, 0, LBU, 32'h103,     RD,           32'h0,        5'd10,
                      1, 1, 0, 1, 32'h00000080, 5'd10, 32'd2);
        step("lh",    1, 0, 0, LH,  32'h102,     RD,           32'h0,        5'd11,
                      1, 1, 0, 1, 32'hFFFF80FF, 5'd11, 32'd3);
        step("lhu",   1, 0, 0, LHU, 32'h102,     RD,           32'h0,        5'd12,
                      1, 1, 0, 1, 32'h000080FF, 5'd12, 32'd4);
        step("lh_mis", 1, 0, 0, LH, 32'h101,     RD,           32'h0,        5'd13,
                      1, 0, 1, 1, 32'h00007F01, 5'd13, 32'd5);
        step("lw_mis", 1, 0, 0, LW, 32'h102,     RD,           32'h0,        5'd14,
                      1, 0, 1, 1, 32'h80FF7F01, 5'd14, 32'd5);
        step("jal",   1, 0, 0, JAL, 32'h0,       32'h0,        32'h00400010, 5'd31,
                      1, 1, 0, 1, 32'h00400010, 5'd31, 32'd5);
        step("jal_r0", 1, 0, 0, JAL, 32'h0,      32'h0,        32'h00400010, 5'd0,
                      1, 0, 0, 1, 32'h00400010, 5'd0, 32'd6);
        step("alu",   1, 0, 0, ALU, 32'h12345678, 32'h0,       32'h0,        5'd5,
                      1, 1, 0, 1, 32'h12345678, 5'd5, 32'd6);
        step("stall1", 1, 1, 0, LW, 32'h200,     32'h11111111, 32'h4,        5'd7,
                      1, 1, 0, 1, 32'h12345678, 5'd5, 32'd6);
        step("stall2", 1, 1, 0, LB, 32'h201,     32'h22222222, 32'h8,        5'd8,
                      1, 1, 0, 1, 32'h12345678, 5'd5, 32'd6);
        step("stall3", 1, 1, 0, JAL, 32'h202,    32'h33333333, 32'hC,        5'd9,
                      1, 1, 0, 1, 32'h12345678, 5'd5, 32'd6);
        step("resume", 1, 0, 0, ALU, 32'hCAFEF00D, 32'h0,      32'h0,        5'd6,
                      1, 1, 0, 1, 32'hCAFEF00D, 5'd6, 32'd7);
        step("fl_st", 1, 1, 1, ALU, 32'h77,      32'h0,        32'h0,        5'd3,
                      0, 0, 0, 0, 32'h0,        5'd0, 32'd7);
        step("novalid", 0, 0, 0, ALU, 32'h55,    32'h0,        32'h0,        5'd4,
                      0, 0, 0, 1, 32'h55,       5'd4, 32'd7);
        step("flush", 1, 0, 1, ALU, 32'h66,      32'h0,        32'h0,        5'd3,
                      0, 0, 0, 0, 32'h0,        5'd0, 32'd7);
        drain();

        // Fresh reset, then 16 writes so the 4-bit counter wraps.
        rst_n = 1'b0;
        #1;
        chk_zero("rereset");
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step($sformatf("w%0d", i), 1, 0, 0, ALU, 32'(i), 32'h0, 32'h0, 5'((i % 31) + 1),
                 1, 1, 0, 1, 32'(i), 5'((i % 31) + 1), 32'(i - 1));
        end
        step("wrap",  0, 0, 0, 6'h0, 32'h0,      32'h0,        32'h0,        5'd0,
                      0, 0, 0, 1, 32'h0,        5'd0, 32'd16);
        step("w17",   1, 0, 0, ALU, 32'hABCD,    32'h0,        32'h0,        5'd7,
                      1, 1, 0, 1, 32'hABCD,     5'd7, 32'd16);
        drain();

        // Asynchronous reset between edges while a write is presented.
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
